// File: rtl/q_to_fp_pkg.sv
// Shared definitions for the fixed-point to floating-point normaliser and its consumers.
// Q_WIDTH gives the total bit width of a signed Q(I.F) word.
`ifndef Q_WIDTH
`define Q_WIDTH(I, F) ((I) + (F))
`endif

package q_to_fp_pkg;

  localparam int IN_I_DEF  = 8;
  localparam int IN_F_DEF  = 8;
  localparam int MAN_W_DEF = 12;
  localparam int EXP_W_DEF = 6;

  typedef struct packed {
    logic                        sign;
    logic signed [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0]        man;
    logic                        zero;
  } fp_t;

  // Round-to-nearest-even: bump only above half, or at exactly half with an odd LSB.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/q_lzc.sv
// Combinational leading-zero counter; count_o == W when the input is all zeros.
module q_lzc #(
  parameter int W = 16
) (
  input  logic [W-1:0]           data_i,
  output logic [$clog2(W+1)-1:0] count_o,
  output logic                   all_zero_o
);

  localparam int CW = $clog2(W + 1);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      count_o = data_i[i] ? CW'(W - 1 - i) : count_o;
    end
  end

  assign all_zero_o = ~|data_i;

endmodule

// File: rtl/q_to_fp.sv
// Two-stage valid/ready normaliser: signed Q(IN_I.IN_F) in, {sign, exp, man, zero} out.
// Stage 1 takes sign/magnitude, stage 2 normalises and rounds to nearest even.
module q_to_fp
  import q_to_fp_pkg::*;
#(
  parameter  int IN_I  = 8,
  parameter  int IN_F  = 8,
  parameter  int MAN_W = 12,
  parameter  int EXP_W = 6,
  localparam int W_IN  = `Q_WIDTH(IN_I, IN_F)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_IN-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0]        out_man,
  output logic                    out_zero
);

  localparam int CNT_W   = $clog2(W_IN + 1);
  localparam int DROP    = W_IN - MAN_W;
  localparam int EXP_MIN = -(2 ** (EXP_W - 1));
  localparam int EXP_MAX = (2 ** (EXP_W - 1)) - 1;

  generate
    if ((-IN_F < EXP_MIN) || ((W_IN - IN_F) > EXP_MAX)) begin : g_exp_w_chk
      $error("q_to_fp: EXP_W=%0d cannot hold exponents in [%0d, %0d]", EXP_W, -IN_F, W_IN - IN_F);
    end
  endgenerate

  logic                    adv1_s;
  logic                    adv2_s;
  logic                    v1_q, v1_d;
  logic                    v2_q, v2_d;
  logic                    s1_sign_q, s1_sign_d;
  logic [W_IN-1:0]         s1_mag_q, s1_mag_d;
  logic                    s2_sign_q, s2_sign_d;
  logic signed [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0]        s2_man_q, s2_man_d;
  logic                    s2_zero_q, s2_zero_d;

  logic [CNT_W-1:0]        lzc_s;
  logic                    mag_zero_s;
  logic [W_IN-1:0]         norm_s;
  logic signed [EXP_W-1:0] exp_base_s;
  logic [MAN_W-1:0]        man_trunc_s;
  logic                    guard_s;
  logic                    sticky_s;
  logic                    inc_s;
  logic [MAN_W:0]          man_sum_s;
  logic                    res_sign_s;
  logic signed [EXP_W-1:0] res_exp_s;
  logic [MAN_W-1:0]        res_man_s;
  logic                    res_zero_s;

  // A stage may load when it is empty or its word is leaving this cycle.
  always_comb begin
    adv2_s = !v2_q || out_ready;
    adv1_s = !v1_q || adv2_s;
  end

  assign in_ready = adv1_s;

  always_comb begin
    v1_d      = v1_q;
    s1_sign_d = s1_sign_q;
    s1_mag_d  = s1_mag_q;
    if (adv1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_data[W_IN-1];
        s1_mag_d  = in_data[W_IN-1] ? (~in_data + W_IN'(1)) : in_data;
      end else begin
        s1_mag_d = s1_mag_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  q_lzc #(.W(W_IN)) u_lzc (
    .data_i     (s1_mag_q),
    .count_o    (lzc_s),
    .all_zero_o (mag_zero_s)
  );

  assign norm_s     = s1_mag_q << lzc_s;
  assign exp_base_s = EXP_W'(W_IN - 1 - IN_F) - EXP_W'(lzc_s);

  generate
    if (DROP <= 0) begin : g_pad
      assign man_trunc_s = MAN_W'(norm_s) << (MAN_W - W_IN);
      assign guard_s     = 1'b0;
      assign sticky_s    = 1'b0;
    end else begin : g_trunc
      assign man_trunc_s = norm_s[W_IN-1 -: MAN_W];
      assign guard_s     = norm_s[DROP-1];
      if (DROP >= 2) begin : g_sticky
        assign sticky_s = |norm_s[DROP-2:0];
      end else begin : g_no_sticky
        assign sticky_s = 1'b0;
      end
    end
  endgenerate

  // Round the truncated mantissa; a carry-out renormalises to 1.0 one binade up.
  always_comb begin
    inc_s     = rne_inc(guard_s, sticky_s, man_trunc_s[0]);
    man_sum_s = {1'b0, man_trunc_s} + {{MAN_W{1'b0}}, inc_s};
    if (mag_zero_s) begin
      res_sign_s = 1'b0;
      res_exp_s  = '0;
      res_man_s  = '0;
      res_zero_s = 1'b1;
    end else if (man_sum_s[MAN_W]) begin
      res_sign_s = s1_sign_q;
      res_exp_s  = exp_base_s + EXP_W'(1);
      res_man_s  = {1'b1, {(MAN_W-1){1'b0}}};
      res_zero_s = 1'b0;
    end else begin
      res_sign_s = s1_sign_q;
      res_exp_s  = exp_base_s;
      res_man_s  = man_sum_s[MAN_W-1:0];
      res_zero_s = 1'b0;
    end
  end

  always_comb begin
    v2_d      = v2_q;
    s2_sign_d = s2_sign_q;
    s2_exp_d  = s2_exp_q;
    s2_man_d  = s2_man_q;
    s2_zero_d = s2_zero_q;
    if (adv2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_sign_d = res_sign_s;
        s2_exp_d  = res_exp_s;
        s2_man_d  = res_man_s;
        s2_zero_d = res_zero_s;
      end else begin
        s2_man_d = s2_man_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset drops any in-flight word and clears the outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_man_q  <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      v2_q      <= v2_d;
      s2_sign_q <= s2_sign_d;
      s2_exp_q  <= s2_exp_d;
      s2_man_q  <= s2_man_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  assign out_valid = v2_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_man   = s2_man_q;
  assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_q_to_fp.sv
// Scoreboard bench for q_to_fp: the driver queues hand-computed results on accept,
// the monitor pops and compares whenever a result is taken.
module tb_q_to_fp;
  import q_to_fp_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        sign;
    int          expo;
    logic [11:0] man;
    logic        zero;
  } vec_t;

  typedef struct {
    logic        sign;
    int          expo;
    logic [11:0] man;
    logic        zero;
    int          acc_cyc;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic signed [5:0]  out_exp;
  logic [11:0]        out_man;
  logic               out_zero;

  vec_t vecs[14];
  exp_t sb[$];
  exp_t mon_e;
  fp_t  held;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   inflight = 0;
  int   ready_mode = 0;
  int   t0;
  bit   lat_chk = 1'b0;
  bit   stall_q = 1'b0;
  bit   mon_acc;
  bit   mon_pop;

  q_to_fp dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_zero  (out_zero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send(input int idx);
    int budget = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = vecs[idx].data;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back('{vecs[idx].sign, vecs[idx].expo, vecs[idx].man, vecs[idx].zero, cyc});
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 500) begin
          n_chk++;
          n_fail++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", budget);
          done = 1'b1;
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(posedge clock);
      #1;
      b++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = random, other = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake rule, hold-while-stalled, in-order results and latency.
  always @(negedge clock) begin
    if (!reset_n) begin
      inflight = 0;
      stall_q  = 1'b0;
    end else begin
      check("in_ready", in_ready, (inflight < 2) || out_ready);
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_sign, out_exp, out_man, out_zero}, held);
      end
      mon_acc = in_valid && in_ready;
      mon_pop = out_valid && out_ready;
      if (mon_pop) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got man %0h with empty scoreboard, expected none", out_man);
        end else begin
          mon_e = sb.pop_front();
          check("sign", out_sign, mon_e.sign);
          check("exp", $signed(out_exp), mon_e.expo);
          check("man", out_man, mon_e.man);
          check("zero", out_zero, mon_e.zero);
          if (lat_chk) check("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
      stall_q  = out_valid && !out_ready;
      held     = {out_sign, out_exp, out_man, out_zero};
      inflight = inflight + int'(mon_acc) - int'(mon_pop);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h0100, 1'b0,  0, 12'h800, 1'b0};
    vecs[1]  = '{16'hFC80, 1'b1,  1, 12'hE00, 1'b0};
    vecs[2]  = '{16'h0001, 1'b0, -8, 12'h800, 1'b0};
    vecs[3]  = '{16'h8000, 1'b1,  7, 12'h800, 1'b0};
    vecs[4]  = '{16'h0000, 1'b0,  0, 12'h000, 1'b1};
    vecs[5]  = '{16'h1003, 1'b0,  4, 12'h802, 1'b0};
    vecs[6]  = '{16'h1001, 1'b0,  4, 12'h800, 1'b0};
    vecs[7]  = '{16'h1FFF, 1'b0,  5, 12'h800, 1'b0};
    vecs[8]  = '{16'h7FFF, 1'b0,  7, 12'h800, 1'b0};
    vecs[9]  = '{16'hFFFF, 1'b1, -8, 12'h800, 1'b0};
    vecs[10] = '{16'h0280, 1'b0,  1, 12'hA00, 1'b0};
    vecs[11] = '{16'h7FF5, 1'b0,  6, 12'hFFF, 1'b0};
    vecs[12] = '{16'h7FF3, 1'b0,  6, 12'hFFE, 1'b0};
    vecs[13] = '{16'h100B, 1'b0,  4, 12'h806, 1'b0};
    in_valid = 1'b0;
    in_data  = 16'h0000;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_sign, out_exp, out_man, out_zero}, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Isolated words, then back-to-back, both with a 2-cycle latency check.
    lat_chk = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(i);
      in_valid = 1'b0;
      drain();
    end
    for (int i = 0; i < 14; i++) send(i);
    in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) send((i + r * 5) % 14);
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
    end
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clock);
    #1;

    // Full-throughput stream.
    lat_chk = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100; k++) send(k % 14);
    in_valid = 1'b0;
    check("throughput_cycles", cyc - t0, 100);
    drain();
    lat_chk = 1'b0;

    // Reset with both stages occupied.
    ready_mode = 2;
    repeat (2) @(posedge clock);
    #1;
    send(1);
    send(3);
    in_valid = 1'b0;
    @(negedge clock);
    check("full_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    sb.delete();
    ready_mode = 0;
    @(negedge clock);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", {out_sign, out_exp, out_man, out_zero}, 0);
    @(posedge clock);
    #1;
    lat_chk = 1'b1;
    send(5);
    in_valid = 1'b0;
    drain();
    send(1);
    in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
